muldiv_ctrl: RTL and testbench

Sequencing controller for the CPU's shared multiply/divide unit. It accepts MULT/DIV requests from the multicycle control unit, converts signed operands to magnitudes, and steps one shared 32-iteration shift-add / restoring-subtract datapath. It then applies sign correction and commits the result into architectural HI/LO registers. It also services MTHI/MTLO writes and flags division by zero.

---
 rtl/muldiv_pkg.sv | 16 +
 rtl/muldiv_step.sv | 37 +++
 rtl/muldiv_ctrl.sv | 150 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and encodings for the multiply/divide sequencer.
package muldiv_pkg;

    localparam int unsigned DEF_WIDTH = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring divide.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic               op_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   operand_i,
    input  logic               bit_i,
    output logic [2*WIDTH-1:0] acc_nxt_c,
    output logic               q_bit_c
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;

    // MULT: bit_i is the multiplier LSB. DIV: bit_i is the next dividend bit entering rem.
    always_comb begin
        sum       = '0;
        rem_sh    = '0;
        diff      = '0;
        acc_nxt_c = acc_i;
        q_bit_c   = 1'b0;
        if (op_i == OP_MULT) begin
            sum       = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (bit_i ? {1'b0, operand_i} : '0);
            acc_nxt_c = {sum, acc_i[WIDTH-1:1]};
        end else begin
            rem_sh    = {acc_i[2*WIDTH-1:WIDTH], bit_i};
            diff      = rem_sh[WIDTH-1:0] - operand_i;
            q_bit_c   = (rem_sh >= {1'b0, operand_i});
            acc_nxt_c = {(q_bit_c ? diff : rem_sh[WIDTH-1:0]), acc_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: sign handling, 32-step iteration, HI/LO commit and MTHI/MTLO.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] valueA,
    input  logic [WIDTH-1:0] valueB,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             divZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned      CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic               op_q, op_d;
    logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d, shreg_q, shreg_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d, done_q, done_d, dz_q, dz_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] step_acc, prod;
    logic               step_qbit, step_bit;

    assign mag_a = valueA[WIDTH-1] ? -valueA : valueA;
    assign mag_b = valueB[WIDTH-1] ? -valueB : valueB;

    // opnd holds the multiplicand or divisor; shreg shifts out multiplier LSBs or dividend MSBs.
    assign step_bit = (op_q == OP_MULT) ? shreg_q[0] : shreg_q[WIDTH-1];

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op_i      (op_q),
        .acc_i     (acc_q),
        .operand_i (opnd_q),
        .bit_i     (step_bit),
        .acc_nxt_c (step_acc),
        .q_bit_c   (step_qbit)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        opnd_d   = opnd_q;
        shreg_d  = shreg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dz_d     = 1'b0;
        prod     = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op == OP_DIV && valueB == '0) begin
                        state_d = DONE;
                        dz_d    = 1'b1;
                    end else begin
                        state_d  = RUN;
                        op_d     = op;
                        sign_a_d = valueA[WIDTH-1];
                        sign_b_d = valueB[WIDTH-1];
                        opnd_d   = (op == OP_MULT) ? mag_a : mag_b;
                        shreg_d  = (op == OP_MULT) ? mag_b : mag_a;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end
                end else begin
                    if (hi_wr) hi_d = wdata;
                    if (lo_wr) lo_d = wdata;
                end
            end
            RUN: begin
                acc_d   = {step_acc[2*WIDTH-1:1], step_acc[0] | step_qbit};
                shreg_d = (op_q == OP_MULT) ? (shreg_q >> 1) : (shreg_q << 1);
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) state_d = FIX;
            end
            FIX: begin
                if (op_q == OP_MULT) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else begin
                    // Remainder follows the dividend's sign; quotient follows the sign product.
                    lo_d = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            op_q     <= OP_MULT;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            opnd_q   <= '0;
            shreg_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            opnd_q   <= opnd_d;
            shreg_q  <= shreg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign divZero = dz_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl.
module tb_muldiv_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] valueA = '0;
    logic [31:0] valueB = '0;
    logic        hi_wr = 1'b0;
    logic        lo_wr = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done, divZero;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;

    int done_at, done_cnt, busy_cnt, dz_cnt;
    bit timeout;

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .valueA  (valueA),
        .valueB  (valueB),
        .hi_wr   (hi_wr),
        .lo_wr   (lo_wr),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .divZero (divZero),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clock = ~clock;

    // Issue one request; i counts cycles after the start edge. Optionally pokes start/hi_wr mid-run.
    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                          input logic wr_with_start, input int inject_at);
        @(negedge clock);
        start = 1'b1; op = o; valueA = a; valueB = b;
        hi_wr = wr_with_start; lo_wr = wr_with_start; wdata = 32'h55;
        @(posedge clock); #1;
        start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
        done_at = -1; done_cnt = 0; busy_cnt = 0; dz_cnt = 0; timeout = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (i == inject_at) begin
                start = 1'b1; op = 1'b0; valueA = 32'd9; valueB = 32'd9;
                hi_wr = 1'b1; wdata = 32'hAA;
            end else begin
                start = 1'b0; hi_wr = 1'b0;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            if (divZero) dz_cnt++;
            if (!busy) begin
                timeout = 1'b0;
                break;
            end
            @(posedge clock); #1;
        end
        start = 1'b0; hi_wr = 1'b0;
        checks++;
        if (timeout) begin
            errors++;
            $display("FAIL op_timeout: got busy stuck high, expected release within 100 cycles");
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (divZero !== 1'b0) begin errors++; $display("FAIL reset_divzero: got %b expected 0", divZero); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_mult();
        run_op(1'b0, 32'd7, 32'hFFFFFFFD, 1'b0, -1);
        checks++; if (done_at !== 33) begin errors++; $display("FAIL mult_done_latency: got %0d expected 33", done_at); end
        checks++; if (busy_cnt !== 34) begin errors++; $display("FAIL mult_busy_cycles: got %0d expected 34", busy_cnt); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL mult_done_width: got %0d expected 1", done_cnt); end
        checks++; if (dz_cnt !== 0) begin errors++; $display("FAIL mult_divzero: got %0d expected 0", dz_cnt); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_neg_hi: got %h expected ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_neg_lo: got %h expected ffffffeb", lo); end

        run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, -1);
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL mult_m1m1_hi: got %h expected 0", hi); end
        checks++; if (lo !== 32'h1) begin errors++; $display("FAIL mult_m1m1_lo: got %h expected 1", lo); end

        run_op(1'b0, 32'h80000000, 32'h80000000, 1'b0, -1);
        checks++; if (hi !== 32'h40000000) begin errors++; $display("FAIL mult_min_hi: got %h expected 40000000", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL mult_min_lo: got %h expected 0", lo); end
    endtask

    task automatic test_div();
        run_op(1'b1, 32'hFFFFFFF9, 32'd2, 1'b0, -1);
        checks++; if (done_at !== 33) begin errors++; $display("FAIL div_done_latency: got %0d expected 33", done_at); end
        checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_negdvd_lo: got %h expected fffffffd", lo); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_negdvd_hi: got %h expected ffffffff", hi); end

        run_op(1'b1, 32'd7, 32'hFFFFFFFE, 1'b0, -1);
        checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_negdvs_lo: got %h expected fffffffd", lo); end
        checks++; if (hi !== 32'h1) begin errors++; $display("FAIL div_negdvs_hi: got %h expected 1", hi); end

        run_op(1'b1, 32'd100, 32'd7, 1'b0, -1);
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL div_pos_lo: got %h expected e", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL div_pos_hi: got %h expected 2", hi); end
    endtask

    task automatic test_div_zero();
        @(negedge clock);
        hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'h33;
        @(negedge clock);
        hi_wr = 1'b1; lo_wr = 1'b0; wdata = 32'h11;
        #1;
        checks++; if (hi !== 32'h33 || lo !== 32'h33) begin errors++; $display("FAIL mt_both: got hi=%h lo=%h expected 33/33", hi, lo); end
        @(negedge clock);
        hi_wr = 1'b0; lo_wr = 1'b1; wdata = 32'h22;
        @(negedge clock);
        lo_wr = 1'b0;
        checks++; if (hi !== 32'h11 || lo !== 32'h22) begin errors++; $display("FAIL mt_single: got hi=%h lo=%h expected 11/22", hi, lo); end

        run_op(1'b1, 32'd5, 32'd0, 1'b0, -1);
        checks++; if (done_at !== 0) begin errors++; $display("FAIL dz_done_latency: got %0d expected 0", done_at); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL dz_done_width: got %0d expected 1", done_cnt); end
        checks++; if (dz_cnt !== 1) begin errors++; $display("FAIL dz_flag_width: got %0d expected 1", dz_cnt); end
        checks++; if (hi !== 32'h11) begin errors++; $display("FAIL dz_hi_kept: got %h expected 11", hi); end
        checks++; if (lo !== 32'h22) begin errors++; $display("FAIL dz_lo_kept: got %h expected 22", lo); end
    endtask

    task automatic test_div_overflow();
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, -1);
        checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL ovf_lo: got %h expected 80000000", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL ovf_hi: got %h expected 0", hi); end
        checks++; if (dz_cnt !== 0) begin errors++; $display("FAIL ovf_divzero: got %0d expected 0", dz_cnt); end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clock);
        hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'h77;
        @(negedge clock);
        hi_wr = 1'b0; lo_wr = 1'b0;
        start = 1'b1; op = 1'b0; valueA = 32'd5; valueB = 32'd6;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstrun_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstrun_done: got %b expected 0", done); end
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL rstrun_hilo: got hi=%h lo=%h expected 0/0", hi, lo); end
        @(negedge clock);
        reset = 1'b1;

        // hi_wr/lo_wr asserted alongside start must be dropped.
        run_op(1'b0, 32'd3, 32'd4, 1'b1, -1);
        checks++; if (done_at !== 33) begin errors++; $display("FAIL rstrun_next_latency: got %0d expected 33", done_at); end
        checks++; if (lo !== 32'd12) begin errors++; $display("FAIL rstrun_next_lo: got %h expected c", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rstrun_next_hi: got %h expected 0", hi); end
    endtask

    task automatic test_busy_ignore();
        run_op(1'b1, 32'd100, 32'd7, 1'b0, 5);
        checks++; if (done_at !== 33) begin errors++; $display("FAIL busy_ign_latency: got %0d expected 33", done_at); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL busy_ign_done_width: got %0d expected 1", done_cnt); end
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL busy_ign_lo: got %h expected e", lo); end
        checks++; if (hi !== 32'd2) begin errors++; $display("FAIL busy_ign_hi: got %h expected 2", hi); end
        repeat (3) @(posedge clock);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_ign_no_requeue: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        run_op(1'b0, 32'd6, 32'hFFFFFFFB, 1'b0, -1);
        checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFE2) begin errors++; $display("FAIL b2b_mult: got hi=%h lo=%h expected ffffffff/ffffffe2", hi, lo); end
        run_op(1'b1, 32'hFFFFFF9C, 32'd7, 1'b0, -1);
        checks++; if (done_at !== 33) begin errors++; $display("FAIL b2b_div_latency: got %0d expected 33", done_at); end
        checks++; if (lo !== 32'hFFFFFFF2) begin errors++; $display("FAIL b2b_div_lo: got %h expected fffffff2", lo); end
        checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL b2b_div_hi: got %h expected fffffffe", hi); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_div_overflow();
        test_reset_mid_run();
        test_busy_ignore();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
